// File: rtl/truth_table_scanner.sv
// Sweeps a 4-input function block through all 16 vectors, captures its truth table
// and compares it against an expected minterm mask.
module truth_table_scanner #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] expected,
   input  logic        S,
   output logic        X,
   output logic        Y,
   output logic        W,
   output logic        Z,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic        match,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
   localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  idx;
   logic [3:0]  wait_cnt;
   logic [15:0] exp_q;
   logic        accept;
   logic        mismatch;

   assign accept   = (state == IDLE) && start && !abort;
   assign mismatch = S ^ exp_q[idx];

   // The index register doubles as the applied vector so it holds between scans.
   assign {X, Y, W, Z} = idx;
   assign busy         = (state == SETTLE) || (state == SAMPLE);
   assign done         = (state == FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = NO_SETTLE ? SAMPLE : SETTLE;
         SETTLE: begin
            if (abort)                 state_nxt = IDLE;
            else if (wait_cnt == 4'd1) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (abort)              state_nxt = IDLE;
            else if (idx == 4'd15)  state_nxt = FINISH;
            else                    state_nxt = NO_SETTLE ? SAMPLE : SETTLE;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         wait_cnt   <= '0;
         exp_q      <= '0;
         table_out  <= '0;
         fail_count <= '0;
         first_fail <= '0;
         match      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  exp_q      <= expected;
                  idx        <= '0;
                  wait_cnt   <= SETTLE_LD;
                  table_out  <= '0;
                  fail_count <= '0;
                  first_fail <= '0;
                  match      <= 1'b0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  idx        <= '0;
                  table_out  <= '0;
                  fail_count <= '0;
                  first_fail <= '0;
                  match      <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  idx        <= '0;
                  table_out  <= '0;
                  fail_count <= '0;
                  first_fail <= '0;
                  match      <= 1'b0;
               end else begin
                  table_out[idx] <= S;
                  if (mismatch) begin
                     fail_count <= fail_count + 5'd1;
                     if (fail_count == 5'd0) first_fail <= idx;
                  end
                  // match is resolved here so it is already valid during the done cycle.
                  if (idx == 4'd15) begin
                     match <= (fail_count == 5'd0) && !mismatch;
                  end else begin
                     idx      <= idx + 4'd1;
                     wait_cnt <= SETTLE_LD;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (settle 0, 1, 3) each driving a
// table-lookup evaluator, checked against a truth-table model of the scan.
module tb_truth_table_scanner;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_v [N];
   logic        abort_v [N];
   logic [15:0] exp_v [N];
   logic        s_v [N];
   logic        x_v [N];
   logic        y_v [N];
   logic        w_v [N];
   logic        z_v [N];
   logic        busy_v [N];
   logic        done_v [N];
   logic [15:0] tbl_v [N];
   logic        match_v [N];
   logic [4:0]  fc_v [N];
   logic [3:0]  ff_v [N];
   logic [15:0] func_tbl [N];

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      truth_table_scanner #(.SETTLE_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))) dut (
         .clk(clk), .rst_n(rst_n), .start(start_v[g]), .abort(abort_v[g]),
         .expected(exp_v[g]), .S(s_v[g]),
         .X(x_v[g]), .Y(y_v[g]), .W(w_v[g]), .Z(z_v[g]),
         .busy(busy_v[g]), .done(done_v[g]), .table_out(tbl_v[g]),
         .match(match_v[g]), .fail_count(fc_v[g]), .first_fail(ff_v[g])
      );
      assign s_v[g] = func_tbl[g][{x_v[g], y_v[g], w_v[g], z_v[g]}];
   end

   function automatic int sc_of(input int g);
      return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
   endfunction

   function automatic int popcnt(input logic [15:0] v);
      int c = 0;
      for (int i = 0; i < 16; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic int low_idx(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_outputs(input int g, input string tag, input logic b, input logic d,
                              input logic [3:0] vec, input logic [15:0] tbl,
                              input logic m, input int fc, input int ff);
      chk({tag, " busy"}, 32'(busy_v[g]), 32'(b));
      chk({tag, " done"}, 32'(done_v[g]), 32'(d));
      chk({tag, " vector"}, 32'({x_v[g], y_v[g], w_v[g], z_v[g]}), 32'(vec));
      chk({tag, " table_out"}, 32'(tbl_v[g]), 32'(tbl));
      chk({tag, " match"}, 32'(match_v[g]), 32'(m));
      chk({tag, " fail_count"}, 32'(fc_v[g]), fc);
      chk({tag, " first_fail"}, 32'(ff_v[g]), ff);
   endtask

   // Full scan: latency and results follow directly from the function and expected mask.
   task automatic run_scan(input int g, input logic [15:0] func, input logic [15:0] expm,
                           input int pulse_at, input bit hold, input string tag);
      int n;
      bit got;
      logic [15:0] diff;
      func_tbl[g] = func;
      exp_v[g] = expm;
      @(negedge clk);
      start_v[g] = 1'b1;
      @(posedge clk);
      n = 0;
      got = 1'b0;
      while (n < 300 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            if (!hold) start_v[g] = 1'b0;
            chk({tag, " busy_rise"}, 32'(busy_v[g]), 32'(1));
         end
         if (pulse_at > 0 && n == pulse_at) start_v[g] = 1'b1;
         if (pulse_at > 0 && n == pulse_at + 1 && !hold) start_v[g] = 1'b0;
         if (done_v[g]) got = 1'b1;
      end
      diff = func ^ expm;
      chk({tag, " latency"}, 32'(n), 32'(16 * (sc_of(g) + 1) + 1));
      chk_outputs(g, {tag, " at_done"}, 1'b0, 1'b1, 4'd15, func, (diff == 16'h0),
                  popcnt(diff), low_idx(diff));
      if (!hold) begin
         @(negedge clk);
         chk_outputs(g, {tag, " after_done"}, 1'b0, 1'b0, 4'd15, func, (diff == 16'h0),
                     popcnt(diff), low_idx(diff));
      end
   endtask

   initial begin
      int n;
      int seen;
      int g;
      logic [15:0] f;
      logic [15:0] e;
      for (int i = 0; i < N; i++) begin
         start_v[i] = 1'b0;
         abort_v[i] = 1'b0;
         exp_v[i] = 16'h0;
         func_tbl[i] = 16'h0;
      end

      // Reset state
      #1;
      for (int i = 0; i < N; i++) chk_outputs(i, "reset", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // start and abort together in IDLE: abort wins
      start_v[1] = 1'b1;
      abort_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      abort_v[1] = 1'b0;
      chk("start_abort busy", 32'(busy_v[1]), 32'(0));
      @(negedge clk);
      chk("start_abort busy2", 32'(busy_v[1]), 32'(0));

      // Directed cases from the maxterm function
      run_scan(1, 16'h77B0, 16'h77B0, 0, 1'b0, "exact");
      run_scan(1, 16'h77B0, 16'h77B1, 0, 1'b0, "bit0");
      run_scan(1, 16'h77B0, 16'hF7B0, 0, 1'b0, "bit15");
      run_scan(1, 16'h77B0, 16'h884F, 0, 1'b0, "complement");
      run_scan(0, 16'h77B0, 16'h77B0, 0, 1'b0, "settle0");
      run_scan(2, 16'h77B0, 16'h77B0, 0, 1'b0, "settle3");
      run_scan(1, 16'h77B0, 16'h77B0, 5, 1'b0, "pulse_busy");

      // Randomized functions and masks
      for (int k = 0; k < 6; k++) begin
         g = int'($urandom_range(0, 2));
         f = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       e = f;
            1:       e = f ^ (16'h1 << $urandom_range(0, 15));
            default: e = 16'($urandom);
         endcase
         run_scan(g, f, e, 0, 1'b0, "random");
      end

      // Abort at cycle 10 of a scan with mismatches already counted
      func_tbl[1] = 16'h77B0;
      exp_v[1] = 16'h884F;
      @(negedge clk);
      start_v[1] = 1'b1;
      @(posedge clk);
      for (n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) start_v[1] = 1'b0;
      end
      abort_v[1] = 1'b1;
      @(negedge clk);
      abort_v[1] = 1'b0;
      chk_outputs(1, "abort", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 0, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_v[1]) seen++;
      end
      chk("abort no_done", 32'(seen), 32'(0));
      chk_outputs(1, "abort hold", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 0, 0);
      run_scan(1, 16'h77B0, 16'h77B1, 0, 1'b0, "post_abort");

      // Asynchronous reset mid-scan
      func_tbl[2] = 16'hFFFF;
      exp_v[2] = 16'h0000;
      @(negedge clk);
      start_v[2] = 1'b1;
      @(posedge clk);
      for (n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) start_v[2] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk_outputs(2, "async_rst", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (70) begin
         @(negedge clk);
         if (done_v[2]) seen++;
      end
      chk("rst no_done", 32'(seen), 32'(0));
      chk_outputs(2, "rst hold", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 0, 0);
      run_scan(2, 16'h77B0, 16'h77B0, 0, 1'b0, "post_rst");

      // start held high: back-to-back scans with one idle cycle between
      run_scan(0, 16'h77B0, 16'h77B0, 0, 1'b1, "held1");
      @(negedge clk);
      chk("held gap busy", 32'(busy_v[0]), 32'(0));
      @(negedge clk);
      chk("held restart busy", 32'(busy_v[0]), 32'(1));
      n = 1;
      while (n < 300 && !done_v[0]) begin
         @(negedge clk);
         n++;
      end
      start_v[0] = 1'b0;
      chk("held2 latency", 32'(n), 32'(17));
      chk_outputs(0, "held2", 1'b0, 1'b1, 4'd15, 16'h77B0, 1'b1, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequencer that drives a 4-input combinational boolean evaluator (SoP/PoS function block, inputs X, Y, W, Z, output S) through all 16 input combinations. It samples the evaluator output for each combination, assembles the 16-bit truth table, and compares it against an expected minterm mask. It replaces the hand-written `#1` stimulus sweep with a synthesizable, self-checking controller that sits between a host/test harness and any 4-variable function block.

## Interface
- SETTLE_CYCLES, default 1: idle cycles between applying a vector and sampling S. Legal range 0..15.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  level-sampled request to begin a scan; accepted only in IDLE
- abort  input  1  synchronous cancel; ignored in IDLE
- expected  input  16  expected truth table; bit i = F for index i = {X,Y,W,Z}; sampled at start acceptance
- S  input  1  evaluator output (combinational function of X, Y, W, Z)
- X, Y, W, Z  output  1 each  applied vector; X is index bit 3, Z is index bit 0
- busy  output  1  high in SCAN states
- done  output  1  one-cycle pulse when a full scan completes
- table_out  output  16  captured truth table
- match  output  1  table_out == expected copy; valid from the done pulse onward
- fail_count  output  5  number of mismatching indices (0..16)
- first_fail  output  4  lowest mismatching index; 0 when fail_count == 0

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- Reset (async, rst_n = 0): state IDLE; X, Y, W, Z = 0; busy = 0; done = 0; table_out = 0; match = 0; fail_count = 0; first_fail = 0; index = 0; internal expected copy = 0.
- IDLE: when start = 1 and abort = 0:
  - latch expected; index = 0; clear table_out, fail_count and first_fail; match = 0; wait counter = SETTLE_CYCLES.
  - If SETTLE_CYCLES = 0, go to SAMPLE; otherwise go to SETTLE.
- SETTLE: X, Y, W, Z = index. Decrement the wait counter; go to SAMPLE when the counter reaches 1 (the counter is loaded with SETTLE_CYCLES).
- SAMPLE: table_out[index] <= S. On S != expected[index]:
  - fail_count += 1;
  - first_fail <= index if this is the first mismatch.
  - Then:
    - if index == 15, go to FINISH;
    - otherwise index += 1, reload the wait counter, and go to SETTLE (or SAMPLE when SETTLE_CYCLES = 0).
- FINISH: done = 1 for exactly one cycle; match <= (fail_count == 0), computed including the final sample; go to IDLE.
- In IDLE, X, Y, W, Z hold the last applied vector (15 after a completed scan, 0 after reset or abort). table_out, match, fail_count and first_fail hold until the next accepted start.
- abort = 1 in SETTLE or SAMPLE: next state IDLE, with no sample taken that cycle and no done pulse. X, Y, W, Z, table_out, fail_count, first_fail and match are cleared to 0.
- start while busy is ignored; no queuing.
- start and abort both high in IDLE: abort wins, so the block stays IDLE.
- index is 4 bits and never wraps past 15 within a scan.
- fail_count is 5 bits so the value 16 is representable.

## Timing
- Start accepted at edge T0; the first vector (0) is visible on X, Y, W, Z after T0.
- Each vector occupies SETTLE_CYCLES + 1 cycles, and S is sampled at the end of the last of those cycles.
- done is high during cycle T0 + 16·(SETTLE_CYCLES + 1) + 1; with the default setting that is cycle 33 after acceptance.
- busy rises the cycle after acceptance and falls the cycle done is asserted.
- A new start is accepted no earlier than the cycle after the done pulse.
- S must be stable within SETTLE_CYCLES + 1 clock periods of a vector change; with SETTLE_CYCLES = 0 it must settle within one period.
- rst_n asserted at any point returns all outputs to their reset values immediately, with no clock required.

## Test plan
- Evaluator with maxterms 0,1,2,3,6,11,15, expected = 0x77B0 -> done after 33 cycles; table_out = 0x77B0; match = 1; fail_count = 0; first_fail = 0.
- Same evaluator, expected = 0x77B1 -> table_out = 0x77B0; match = 0; fail_count = 1; first_fail = 0. Repeat with expected = 0xF7B0 -> fail_count = 1, first_fail = 15.
- Same evaluator, expected = 0x884F (the complement) -> fail_count = 16; first_fail = 0; match = 0.
- SETTLE_CYCLES = 0 and 3 -> done latency of 17 and 65 cycles respectively; table_out = 0x77B0 in both cases.
- abort at cycle 10 of a scan, and separately rst_n pulsed low mid-scan -> no done pulse; busy = 0 and all outputs 0. A following start completes normally with correct results.
- start held high continuously -> scans run back-to-back, one idle cycle between done and the next busy; start pulsed while busy -> no effect on latency or result.
